// File: rtl/activ4_pkg.sv
// Shared definitions for the activity-4 serial transmitter: the state
// encoding (exported so benches can display it), the default frame width
// and the frame-length clamp.
package activ4_pkg;

    localparam int TX_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } txstate_t;

    // Requested lengths beyond the register width send the whole register.
    function automatic int unsigned clamp_len(input int unsigned len_req,
                                              input int unsigned width);
        return (len_req > width) ? width : len_req;
    endfunction

endpackage

// File: rtl/activ4_shreg.sv
// Loadable left shift register with zero fill, serial MSB output and a
// running XOR of every bit shifted out (even-parity accumulator).
module activ4_shreg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             shift_i,
    output logic             msb_o,
    output logic             parity_o
);

    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             parity_q, parity_d;

    // Load wins over shift; parity restarts with every new frame.
    always_comb begin
        shreg_d  = shreg_q;
        parity_d = parity_q;
        if (load_i) begin
            shreg_d  = load_data_i;
            parity_d = 1'b0;
        end else if (shift_i) begin
            shreg_d  = {shreg_q[WIDTH-2:0], 1'b0};
            parity_d = parity_q ^ shreg_q[WIDTH-1];
        end
    end

    // Register update with immediate clear on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg_q  <= '0;
            parity_q <= 1'b0;
        end else begin
            shreg_q  <= shreg_d;
            parity_q <= parity_d;
        end
    end

    assign msb_o    = shreg_q[WIDTH-1];
    assign parity_o = parity_q;

endmodule

// File: rtl/activ4_tx.sv
// Serial bit-stream transmitter: loads the low len bits of data_in and sends
// them MSB-first, one bit per step, then pulses done for one cycle.
// Define ACTIV4_TX_PARITY_EN to append an even-parity bit after the data.
module activ4_tx
    import activ4_pkg::*;
#(
    parameter  int WIDTH = TX_WIDTH_DEFAULT,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic [CW-1:0]    len,
    input  logic             step,
    output logic             ready,
    output logic             x,
    output logic             x_valid,
    output logic             done,
    output logic [1:0]       currentState,
    output logic [1:0]       nextState
);

`ifdef ACTIV4_TX_PARITY_EN
    localparam txstate_t AFTER_DATA = PARITY;
`else
    localparam txstate_t AFTER_DATA = DONE;
`endif

    txstate_t         state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    len_eff;
    logic [WIDTH-1:0] load_word;
    logic             accept, shift_en;
    logic             sh_msb, sh_par;

    // Left-align the frame so bit len_eff-1 is the first one out.
    assign len_eff   = CW'(clamp_len(32'(len), 32'(WIDTH)));
    assign load_word = data_in << (CW'(WIDTH) - len_eff);
    assign accept    = (state_q == IDLE) && start && (len != '0);
    assign shift_en  = (state_q == SHIFT) && step;

    activ4_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk        (clk),
        .reset      (reset),
        .load_i     (accept),
        .load_data_i(load_word),
        .shift_i    (shift_en),
        .msb_o      (sh_msb),
        .parity_o   (sh_par)
    );

    // Next-state and bit-counter logic; step=0 freezes SHIFT and PARITY.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = len_eff;
                end
            end
            SHIFT: begin
                if (step) begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = AFTER_DATA;
                    end
                end
            end
            PARITY: begin
                if (step) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers, cleared immediately on reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode only registered state, so they never glitch on inputs.
    always_comb begin
        ready   = (state_q == IDLE);
        done    = (state_q == DONE);
        x_valid = (state_q == SHIFT) || (state_q == PARITY);
        x       = 1'b0;
        if (state_q == SHIFT) begin
            x = sh_msb;
        end else if (state_q == PARITY) begin
            x = sh_par;
        end
    end

    assign currentState = state_q;
    assign nextState    = state_d;

endmodule

// File: tb/tb_activ4_tx.sv
// Self-checking bench for activ4_tx (WIDTH=8): table-driven frames, hand
// sequences for reset and len=0, and randomized frames against a model.
module tb_activ4_tx;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] data_in;
    logic [3:0] len;
    logic       step;
    logic       ready, x, x_valid, done;
    logic [1:0] currentState, nextState;

    int tests = 0;
    int fails = 0;

    activ4_tx dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .data_in     (data_in),
        .len         (len),
        .step        (step),
        .ready       (ready),
        .x           (x),
        .x_valid     (x_valid),
        .done        (done),
        .currentState(currentState),
        .nextState   (nextState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  d;
        logic [3:0]  l;
        logic [15:0] bits;   // expected data bits, first sent at bits[n-1]
        int          n;
        logic        par;    // expected parity bit when parity is built in
        int          mode;   // 0: step=1, 1: step pattern, 2: random step
        logic [15:0] pat;    // step pattern, LSB = first cycle
        bit          poke;   // assert start mid-frame
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Frame as the specification describes it: low min(len,8) bits, MSB first,
    // followed by the XOR of those bits when parity is enabled.
    function automatic void model_bits(input logic [7:0] d, input int l,
                                       output logic [15:0] v, output int n, output int nd);
        int   le;
        logic p;
        le = (l > 8) ? 8 : l;
        v  = '0;
        n  = 0;
        p  = 1'b0;
        for (int i = le - 1; i >= 0; i--) begin
            v = {v[14:0], d[i]};
            p = p ^ d[i];
            n++;
        end
        nd = n;
`ifdef ACTIV4_TX_PARITY_EN
        v = {v[14:0], p};
        n++;
`endif
    endfunction

    // Called at a negedge with the DUT idle; sends one frame and checks every cycle.
    task automatic send_frame(input logic [7:0] d, input logic [3:0] l,
                              input logic [15:0] exp, input int n, input int nd,
                              input int mode, input logic [15:0] pat, input bit poke,
                              input string nm);
        int   idx;
        int   cyc;
        logic st;
        start   = 1'b1;
        data_in = d;
        len     = l;
        step    = 1'b0;
        @(negedge clk);
        start = 1'b0;
        idx   = 0;
        cyc   = 0;
        while (idx < n && cyc < 200) begin
            check($sformatf("%s x_valid[%0d]", nm, idx), x_valid, 1);
            check($sformatf("%s x[%0d]", nm, idx), x, exp[n-1-idx]);
            check($sformatf("%s ready[%0d]", nm, idx), ready, 0);
            check($sformatf("%s done[%0d]", nm, idx), done, 0);
            check($sformatf("%s state[%0d]", nm, idx), currentState, (idx < nd) ? 1 : 2);
            case (mode)
                0:       st = 1'b1;
                1:       st = (cyc < 16) ? pat[cyc] : 1'b1;
                default: st = 1'($urandom_range(0, 1));
            endcase
            step = st;
            if (poke) begin
                start   = 1'($urandom_range(0, 1));
                data_in = ~d;
                len     = 4'd3;
            end
            @(negedge clk);
            if (st) idx++;
            cyc++;
        end
        if (cyc >= 200) check({nm, " timeout"}, 1, 0);
        start = 1'b0;
        step  = 1'($urandom_range(0, 1));
        check({nm, " done"}, done, 1);
        check({nm, " done x_valid"}, x_valid, 0);
        check({nm, " done ready"}, ready, 0);
        check({nm, " done state"}, currentState, 3);
        @(negedge clk);
        check({nm, " end ready"}, ready, 1);
        check({nm, " end done"}, done, 0);
        check({nm, " end state"}, currentState, 0);
        step = 1'b0;
    endtask

    initial begin
        logic [15:0] e;
        int          en, ed;
        logic [7:0]  rd;
        int          rl;

        // data, len, bits, n, parity, mode, pattern, poke
        tbl[0] = '{8'hB5, 4'd4,  16'b0101,     4, 1'b0, 0, 16'h0,        1'b0};
        tbl[1] = '{8'hB5, 4'd4,  16'b0101,     4, 1'b0, 1, 16'b1011001,  1'b0};
        tbl[2] = '{8'hB5, 4'd4,  16'b0101,     4, 1'b0, 0, 16'h0,        1'b1};
        tbl[3] = '{8'h81, 4'd12, 16'b10000001, 8, 1'b0, 0, 16'h0,        1'b0};
        tbl[4] = '{8'h07, 4'd4,  16'b0111,     4, 1'b1, 0, 16'h0,        1'b0};
        tbl[5] = '{8'h05, 4'd4,  16'b0101,     4, 1'b0, 1, 16'b0110,     1'b0};
        tbl[6] = '{8'hFF, 4'd1,  16'b1,        1, 1'b1, 0, 16'h0,        1'b0};
        tbl[7] = '{8'h00, 4'd8,  16'b0,        8, 1'b0, 0, 16'h0,        1'b1};
        tbl[8] = '{8'h3C, 4'd8,  16'b00111100, 8, 1'b0, 1, 16'b1010101,  1'b0};

        // Reset held with start=1: idle outputs, next state already SHIFT.
        reset   = 1'b1;
        start   = 1'b1;
        data_in = 8'hB5;
        len     = 4'd4;
        step    = 1'b1;
        repeat (2) @(negedge clk);
        check("rst ready", ready, 1);
        check("rst x_valid", x_valid, 0);
        check("rst done", done, 0);
        check("rst x", x, 0);
        check("rst state", currentState, 0);
        check("rst nextState", nextState, 1);
        reset = 1'b0;
        model_bits(8'hB5, 4, e, en, ed);
        send_frame(8'hB5, 4'd4, e, en, ed, 0, 16'h0, 1'b0, "rst_first");

        // Table-driven frames with hand-derived expected bits.
        for (int i = 0; i < 9; i++) begin
            e  = tbl[i].bits;
            en = tbl[i].n;
            ed = tbl[i].n;
`ifdef ACTIV4_TX_PARITY_EN
            e = {e[14:0], tbl[i].par};
            en++;
`endif
            send_frame(tbl[i].d, tbl[i].l, e, en, ed, tbl[i].mode, tbl[i].pat,
                       tbl[i].poke, $sformatf("tbl%0d", i));
        end

        // len=0 is ignored.
        start   = 1'b1;
        data_in = 8'hFF;
        len     = 4'd0;
        step    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("len0 ready", ready, 1);
            check("len0 x_valid", x_valid, 0);
            check("len0 state", currentState, 0);
            check("len0 done", done, 0);
        end
        start = 1'b0;

        // Reset mid-SHIFT after two bits: idle at once, no done afterwards.
        start   = 1'b1;
        data_in = 8'hB5;
        len     = 4'd4;
        step    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("mid pre state", currentState, 1);
        reset = 1'b1;
        #1;
        check("mid x_valid", x_valid, 0);
        check("mid ready", ready, 1);
        check("mid state", currentState, 0);
        check("mid x", x, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("mid after done", done, 0);
            check("mid after ready", ready, 1);
        end

        // Randomized frames against the model.
        for (int k = 0; k < 30; k++) begin
            rd = 8'($urandom);
            rl = $urandom_range(0, 15);
            if (rl == 0) begin
                start = 1'b1;
                len   = 4'd0;
                @(negedge clk);
                start = 1'b0;
                check("rnd len0 state", currentState, 0);
            end else begin
                model_bits(rd, rl, e, en, ed);
                send_frame(rd, 4'(rl), e, en, ed, 2, 16'h0,
                           1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
